ex_9_demux: RTL

EX_9_DEMUX -- requirements
Module: ex_9_demux

---
 rtl/ex_9_demux_pkg.sv | 35 +++
 rtl/ex_9_demux_slot.sv | 46 ++++
 rtl/ex_9_demux.sv | 74 +++++++
 3 files changed

// File: rtl/ex_9_demux_pkg.sv
// Shared definitions for the six-way demux: channel indices, channel state, select decoder.
// Decoder is purely combinational; no state lives here.
package ex_9_demux_pkg;

    localparam int NUM_CH   = 6;
    localparam int CH_IDX_W = 3;

    localparam logic [CH_IDX_W-1:0] CH_A = 3'd0;
    localparam logic [CH_IDX_W-1:0] CH_B = 3'd1;
    localparam logic [CH_IDX_W-1:0] CH_C = 3'd2;
    localparam logic [CH_IDX_W-1:0] CH_D = 3'd3;
    localparam logic [CH_IDX_W-1:0] CH_E = 3'd4;
    localparam logic [CH_IDX_W-1:0] CH_F = 3'd5;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

    function automatic logic [CH_IDX_W-1:0] decode_sel(
        input logic s1,
        input logic s2,
        input logic s3,
        input logic s4,
        input logic s5
    );
        if (s1)            return CH_A;
        else if (s2 && s3) return CH_B;
        else if (s2)       return CH_C;
        else if (s4)       return CH_D;
        else if (s5)       return CH_E;
        else               return CH_F;
    endfunction

endpackage

// File: rtl/ex_9_demux_slot.sv
// One-deep output holding register; load-to-output latency 1 cycle.
// Backpressure: free when empty or draining this cycle, so a drain and refill can share an edge.
module ex_9_demux_slot
    import ex_9_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         drain,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         free
);

    ch_state_t state_q;
    ch_state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= CH_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CH_EMPTY: if (load)           state_d = CH_FULL;
            CH_FULL:  if (drain && !load) state_d = CH_EMPTY;
            default:                      state_d = CH_EMPTY;
        endcase
    end

    always_comb begin
        valid = (state_q == CH_FULL);
        free  = (state_q == CH_EMPTY) || drain;
    end

    // Data only moves on a load, so an emptied slot keeps its last word.
    always_ff @(posedge clk) begin
        if (rst)       dout <= '0;
        else if (load) dout <= din;
    end

endmodule

// File: rtl/ex_9_demux.sv
// Priority-decoded 1-to-6 demux into registered channels; input-to-output latency 1 cycle.
// Backpressure: in_ready reflects only the selected channel being free; busy_err latches blocked presentations.
module ex_9_demux
    import ex_9_demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      g,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sel1,
    input  logic              sel2,
    input  logic              sel3,
    input  logic              sel4,
    input  logic              sel5,
    output logic [W-1:0]      a,
    output logic [W-1:0]      b,
    output logic [W-1:0]      c,
    output logic [W-1:0]      d,
    output logic [W-1:0]      e,
    output logic [W-1:0]      f,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              busy_err
);

    logic [CH_IDX_W-1:0] tgt;
    logic [NUM_CH-1:0]   ch_free;
    logic [NUM_CH-1:0]   ch_load;
    logic [NUM_CH-1:0]   ch_drain;
    logic [W-1:0]        ch_dat [NUM_CH];
    logic                accept;

    assign tgt      = decode_sel(sel1, sel2, sel3, sel4, sel5);
    assign in_ready = ch_free[tgt];
    assign accept   = in_valid && in_ready;
    assign ch_load  = accept ? (NUM_CH'(1) << tgt) : '0;
    assign ch_drain = out_valid & out_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        ex_9_demux_slot #(.W(W)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (ch_load[k]),
            .din   (g),
            .drain (ch_drain[k]),
            .dout  (ch_dat[k]),
            .valid (out_valid[k]),
            .free  (ch_free[k])
        );
    end

    assign a = ch_dat[CH_A];
    assign b = ch_dat[CH_B];
    assign c = ch_dat[CH_C];
    assign d = ch_dat[CH_D];
    assign e = ch_dat[CH_E];
    assign f = ch_dat[CH_F];

    always_ff @(posedge clk) begin
        if (rst)         xfer_cnt <= '0;
        else if (accept) xfer_cnt <= xfer_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)                       busy_err <= 1'b0;
        else if (in_valid && !in_ready) busy_err <= 1'b1;
    end

endmodule
